// File: rtl/mem_load_unit.sv
// MEM-stage load path: issues a word read over a req/ack handshake, then extracts and
// zero/sign-extends the addressed byte, half or word for the MEM/WB register.
module mem_load_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exmem_valid,
    input  logic [31:0]           exmem_addr,
    input  logic [2:0]            exmem_ld_type,
    input  logic [4:0]            exmem_rd,
    input  logic                  flush,
    output logic                  ready,
    output logic                  stall,
    output logic                  dmem_req,
    output logic [31:0]           dmem_addr,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  memwb_valid,
    output logic [DATA_WIDTH-1:0] memwb_data,
    output logic [4:0]            memwb_rd,
    output logic                  load_err
);

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t                state;
    logic [1:0]            lane;
    logic [2:0]            ld_type;
    logic [4:0]            pend_rd;
    logic [7:0]            wait_cnt;
    logic                  accept;
    logic                  reserved;
    logic                  misaligned;
    logic                  timeout_hit;
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic [DATA_WIDTH-1:0] load_value;

    assign ready       = (state == IDLE) && !flush;
    assign stall       = (state != IDLE);
    assign accept      = (state == IDLE) && exmem_valid && !flush;
    assign reserved    = (exmem_ld_type > LD_LHU);
    assign misaligned  = ((exmem_ld_type == LD_LW) && (exmem_addr[1:0] != 2'b00)) ||
                         (((exmem_ld_type == LD_LH) || (exmem_ld_type == LD_LHU)) && exmem_addr[0]);
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    // Lane selection uses the offset and type latched at accept, not the live EX/MEM inputs.
    always_comb begin
        byte_val = dmem_rdata[7:0];
        case (lane)
            2'd1:    byte_val = dmem_rdata[15:8];
            2'd2:    byte_val = dmem_rdata[23:16];
            2'd3:    byte_val = dmem_rdata[31:24];
            default: byte_val = dmem_rdata[7:0];
        endcase
        half_val = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_type)
            LD_LB:   load_value = {{24{byte_val[7]}}, byte_val};
            LD_LBU:  load_value = {24'h000000, byte_val};
            LD_LH:   load_value = {{16{half_val[15]}}, half_val};
            LD_LHU:  load_value = {16'h0000, half_val};
            default: load_value = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lane        <= 2'b00;
            ld_type     <= LD_LW;
            pend_rd     <= 5'd0;
            wait_cnt    <= 8'd0;
            dmem_req    <= 1'b0;
            dmem_addr   <= 32'h0;
            memwb_valid <= 1'b0;
            memwb_data  <= '0;
            memwb_rd    <= 5'd0;
            load_err    <= 1'b0;
        end else begin
            memwb_valid <= 1'b0;
            load_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lane    <= exmem_addr[1:0];
                        ld_type <= exmem_ld_type;
                        pend_rd <= exmem_rd;
                        if (misaligned || reserved) begin
                            load_err <= 1'b1;
                        end else begin
                            state     <= REQ;
                            dmem_req  <= 1'b1;
                            dmem_addr <= {exmem_addr[31:2], 2'b00};
                            wait_cnt  <= 8'd0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= IDLE;
                        if (!flush) begin
                            memwb_valid <= 1'b1;
                            memwb_data  <= load_value;
                            memwb_rd    <= pend_rd;
                        end
                    end else if (timeout_hit) begin
                        // A load squashed in its final wait cycle is not reported as a bus error.
                        dmem_req <= 1'b0;
                        load_err <= !flush;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (flush) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (dmem_ack || timeout_hit) begin
                        dmem_req <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: acts as data memory and compares MEM/WB results against a
// scoreboard of extension-model values pushed when each load is issued.
module tb_mem_load_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        exmem_valid;
    logic [31:0] exmem_addr;
    logic [2:0]  exmem_ld_type;
    logic [4:0]  exmem_rd;
    logic        flush;
    logic        ready;
    logic        stall;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        memwb_valid;
    logic [31:0] memwb_data;
    logic [4:0]  memwb_rd;
    logic        load_err;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        int          ready_seen;
        int          stall_cnt;
        int          req_cnt;
        int          valid_cnt;
        int          valid_at;
        int          err_cnt;
        int          err_at;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] addr;
    } obs_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    mem_load_unit #(.DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .exmem_valid   (exmem_valid),
        .exmem_addr    (exmem_addr),
        .exmem_ld_type (exmem_ld_type),
        .exmem_rd      (exmem_rd),
        .flush         (flush),
        .ready         (ready),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_addr     (dmem_addr),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .memwb_valid   (memwb_valid),
        .memwb_data    (memwb_data),
        .memwb_rd      (memwb_rd),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    // Reference extension: shift the addressed lane down to bit 0, then widen.
    function automatic logic [31:0] ext_model(input logic [2:0] t, input logic [31:0] a,
                                              input logic [31:0] w);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> {a[1:0], 3'b000};
        sh = w >> {a[1], 4'b0000};
        case (t)
            3'd0:    return w;
            3'd1:    return {{24{sb[7]}}, sb[7:0]};
            3'd2:    return {24'h0, sb[7:0]};
            3'd3:    return {{16{sh[15]}}, sh[15:0]};
            3'd4:    return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Issues one load and plays memory for a fixed 22-cycle window; wait_acks < 0 never acks.
    task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] w, input int wait_acks, input int flush_at,
                           output obs_t o);
        o = '{default: 0};
        exmem_valid   = 1'b1;
        exmem_ld_type = t;
        exmem_addr    = a;
        exmem_rd      = rd;
        @(negedge clk);
        o.ready_seen = int'(ready);
        @(posedge clk); #1;
        exmem_valid   = 1'b0;
        exmem_addr    = ~a;
        exmem_ld_type = 3'd0;
        exmem_rd      = ~rd;
        for (int k = 1; k <= 22; k++) begin
            flush      = (k == flush_at);
            dmem_ack   = (dmem_req === 1'b1) && (wait_acks >= 0) && (o.req_cnt == wait_acks);
            dmem_rdata = dmem_ack ? w : 32'h5A5A_A5A5;
            @(negedge clk);
            if (stall === 1'b1) o.stall_cnt++;
            if (dmem_req === 1'b1) begin
                if (o.req_cnt == 0) o.addr = dmem_addr;
                o.req_cnt++;
            end
            if (memwb_valid === 1'b1) begin
                o.valid_cnt++;
                if (o.valid_at == 0) o.valid_at = k;
                o.data = memwb_data;
                o.rd   = memwb_rd;
            end
            if (load_err === 1'b1) begin
                o.err_cnt++;
                if (o.err_at == 0) o.err_at = k;
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_compared++;
        if (dmem_req !== 1'b0 || memwb_valid !== 1'b0 || load_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_strobes got req=%b valid=%b err=%b want 0 0 0",
                     dmem_req, memwb_valid, load_err);
        end
        n_compared++;
        if (dmem_addr !== 32'h0 || memwb_data !== 32'h0 || memwb_rd !== 5'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_regs got addr=%h data=%h rd=%0d want 0 0 0",
                     dmem_addr, memwb_data, memwb_rd);
        end
        n_compared++;
        if (stall !== 1'b0 || ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_idle got stall=%b ready=%b want 0 1", stall, ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_load(input string name, input logic [2:0] t, input logic [31:0] a,
                             input logic [4:0] rd, input logic [31:0] w, input int wait_acks);
        exp_t e;
        exp_t got;
        obs_t o;
        e.data = ext_model(t, a, w);
        e.rd   = rd;
        exp_q.push_back(e);
        do_load(t, a, rd, w, wait_acks, 0, o);
        n_compared++;
        if (o.ready_seen != 1) begin
            n_mismatched++;
            $display("[TB] FAIL %s ready got %0d want 1", name, o.ready_seen);
        end
        n_compared++;
        if (o.valid_cnt != 1 || o.valid_at != wait_acks + 2) begin
            n_mismatched++;
            $display("[TB] FAIL %s valid got count=%0d at=%0d want 1 at %0d",
                     name, o.valid_cnt, o.valid_at, wait_acks + 2);
        end
        n_compared++;
        if (o.stall_cnt != wait_acks + 1 || o.req_cnt != wait_acks + 1) begin
            n_mismatched++;
            $display("[TB] FAIL %s stall/req got %0d/%0d want %0d", name,
                     o.stall_cnt, o.req_cnt, wait_acks + 1);
        end
        n_compared++;
        if (o.addr !== {a[31:2], 2'b00} || o.err_cnt != 0) begin
            n_mismatched++;
            $display("[TB] FAIL %s addr/err got %h/%0d want %h/0", name, o.addr, o.err_cnt,
                     {a[31:2], 2'b00});
        end
        got = exp_q.pop_front();
        n_compared++;
        if (o.data !== got.data || o.rd !== got.rd) begin
            n_mismatched++;
            $display("[TB] FAIL %s data got %h rd %0d want %h rd %0d", name, o.data, o.rd,
                     got.data, got.rd);
        end
    endtask

    task automatic test_random_loads();
        logic [2:0]  t;
        logic [1:0]  ln;
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            t  = 3'($urandom_range(0, 4));
            ln = 2'($urandom_range(0, 3));
            if (t == 3'd0) ln = 2'b00;
            else if (t >= 3'd3) ln = ln & 2'b10;
            a = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'(ln);
            test_load("random", t, a, 5'($urandom_range(1, 31)), $urandom,
                      int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_errors();
        logic [2:0]  et[6] = '{3'd3, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] ea[6] = '{32'h101, 32'h202, 32'h103, 32'h100, 32'h104, 32'h108};
        obs_t o;
        for (int i = 0; i < 6; i++) begin
            do_load(et[i], ea[i], 5'd9, 32'h1234_5678, 0, 0, o);
            n_compared++;
            if (o.err_cnt != 1 || o.err_at != 1) begin
                n_mismatched++;
                $display("[TB] FAIL err_%0d load_err got count=%0d at=%0d want 1 at 1",
                         i, o.err_cnt, o.err_at);
            end
            n_compared++;
            if (o.req_cnt != 0 || o.valid_cnt != 0 || o.stall_cnt != 0) begin
                n_mismatched++;
                $display("[TB] FAIL err_%0d activity got req=%0d valid=%0d stall=%0d want 0 0 0",
                         i, o.req_cnt, o.valid_cnt, o.stall_cnt);
            end
        end
    endtask

    task automatic test_flush();
        obs_t o;
        // Flush one cycle after accept, ack two cycles later: request held through the ack.
        do_load(3'd0, 32'h200, 5'd4, 32'hAAAA_5555, 2, 1, o);
        n_compared++;
        if (o.req_cnt != 3 || o.stall_cnt != 3 || o.valid_cnt != 0 || o.err_cnt != 0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_drain got req=%0d stall=%0d valid=%0d err=%0d want 3 3 0 0",
                     o.req_cnt, o.stall_cnt, o.valid_cnt, o.err_cnt);
        end
        do_load(3'd0, 32'h204, 5'd4, 32'hAAAA_5555, 0, 1, o);
        n_compared++;
        if (o.req_cnt != 1 || o.valid_cnt != 0 || o.err_cnt != 0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_with_ack got req=%0d valid=%0d err=%0d want 1 0 0",
                     o.req_cnt, o.valid_cnt, o.err_cnt);
        end
        do_load(3'd0, 32'h208, 5'd4, 32'h0, -1, 2, o);
        n_compared++;
        if (o.req_cnt != TIMEOUT || o.valid_cnt != 0 || o.err_cnt != 0) begin
            n_mismatched++;
            $display("[TB] FAIL drain_timeout got req=%0d valid=%0d err=%0d want %0d 0 0",
                     o.req_cnt, o.valid_cnt, o.err_cnt, TIMEOUT);
        end
    endtask

    task automatic test_flush_idle();
        int act;
        act = 0;
        exmem_valid   = 1'b1;
        exmem_ld_type = 3'd0;
        exmem_addr    = 32'h300;
        flush         = 1'b1;
        @(negedge clk);
        n_compared++;
        if (ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_idle_ready got %b want 0", ready);
        end
        @(posedge clk); #1;
        exmem_valid = 1'b0;
        flush       = 1'b0;
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            act += int'(dmem_req === 1'b1) + int'(memwb_valid === 1'b1) +
                   int'(load_err === 1'b1) + int'(stall === 1'b1);
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        n_compared++;
        if (act != 0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_idle_activity got %0d active samples want 0", act);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_load(3'd0, 32'h200, 5'd6, 32'h0, -1, 0, o);
        n_compared++;
        if (o.req_cnt != TIMEOUT || o.stall_cnt != TIMEOUT) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_req got req=%0d stall=%0d want %0d", o.req_cnt,
                     o.stall_cnt, TIMEOUT);
        end
        n_compared++;
        if (o.err_cnt != 1 || o.err_at != TIMEOUT + 1 || o.valid_cnt != 0) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_err got count=%0d at=%0d valid=%0d want 1 at %0d valid 0",
                     o.err_cnt, o.err_at, o.valid_cnt, TIMEOUT + 1);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        e.data = ext_model(3'd0, 32'h300, 32'hCAFE_0123);
        e.rd   = 5'd7;
        exp_q.push_back(e);
        exmem_valid   = 1'b1;
        exmem_ld_type = 3'd0;
        exmem_addr    = 32'h300;
        exmem_rd      = 5'd7;
        @(posedge clk); #1;
        exmem_valid = 1'b0;
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'hCAFE_0123;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        e.data = ext_model(3'd2, 32'h305, 32'h0000_9A00);
        e.rd   = 5'd8;
        exp_q.push_back(e);
        exmem_valid   = 1'b1;
        exmem_ld_type = 3'd2;
        exmem_addr    = 32'h305;
        exmem_rd      = 5'd8;
        @(negedge clk);
        got = exp_q.pop_front();
        n_compared++;
        if (memwb_valid !== 1'b1 || ready !== 1'b1 || memwb_data !== got.data ||
            memwb_rd !== got.rd) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_first got valid=%b ready=%b data=%h rd=%0d want 1 1 %h %0d",
                     memwb_valid, ready, memwb_data, memwb_rd, got.data, got.rd);
        end
        @(posedge clk); #1;
        exmem_valid = 1'b0;
        dmem_ack    = dmem_req;
        dmem_rdata  = 32'h0000_9A00;
        @(negedge clk);
        n_compared++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h304) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second_req got req=%b addr=%h want 1 00000304",
                     dmem_req, dmem_addr);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        got = exp_q.pop_front();
        n_compared++;
        if (memwb_valid !== 1'b1 || memwb_data !== got.data || memwb_rd !== got.rd) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second got valid=%b data=%h rd=%0d want 1 %h %0d",
                     memwb_valid, memwb_data, memwb_rd, got.data, got.rd);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (memwb_valid !== 1'b0 || memwb_data !== 32'h0000_009A || memwb_rd !== 5'd8) begin
            n_mismatched++;
            $display("[TB] FAIL hold got valid=%b data=%h rd=%0d want 0 0000009a 8",
                     memwb_valid, memwb_data, memwb_rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int act;
        act = 0;
        exmem_valid   = 1'b1;
        exmem_ld_type = 3'd0;
        exmem_addr    = 32'h400;
        exmem_rd      = 5'd3;
        @(posedge clk); #1;
        exmem_valid = 1'b0;
        @(negedge clk);
        n_compared++;
        if (dmem_req !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_pre got req=%b want 1", dmem_req);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_compared++;
        if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_async got req=%b stall=%b want 0 0", dmem_req, stall);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        dmem_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            act += int'(dmem_req === 1'b1) + int'(memwb_valid === 1'b1) +
                   int'(load_err === 1'b1);
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        n_compared++;
        if (act != 0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_after got %0d active samples want 0", act);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b1;
        exmem_valid   = 1'b0;
        exmem_addr    = 32'h0;
        exmem_ld_type = 3'd0;
        exmem_rd      = 5'd0;
        flush         = 1'b0;
        dmem_ack      = 1'b0;
        dmem_rdata    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load("lb_0x103", 3'd1, 32'h103, 5'd1, 32'h80FF_1234, 3);
        test_load("lbu_0x103", 3'd2, 32'h103, 5'd2, 32'h80FF_1234, 3);
        test_load("lh_0x102", 3'd3, 32'h102, 5'd3, 32'h8001_7FFF, 1);
        test_load("lhu_0x102", 3'd4, 32'h102, 5'd4, 32'h8001_7FFF, 2);
        test_load("lh_0x100", 3'd3, 32'h100, 5'd5, 32'h8001_7FFF, 0);
        test_load("lw_best", 3'd0, 32'h204, 5'd31, 32'hDEAD_BEEF, 0);
        test_random_loads();
        test_errors();
        test_flush();
        test_flush_idle();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_empty got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
